// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: in-flight write scoreboard, operand forwarding selects,
// load-use / no-forward stalls and branch squash or freeze for the 8-bit MCU core.
module pipe_hazard_ctrl #(
  parameter int RA_W    = 3,
  parameter int DEPTH   = 3,
  parameter int FWD_EN  = 1,
  parameter int BR_MODE = 0,
  parameter int R0_ZERO = 0,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [RA_W-1:0]  dec_aa,
  input  logic [RA_W-1:0]  dec_ba,
  input  logic             dec_ma,
  input  logic             dec_mb,
  input  logic             dec_rw,
  input  logic [RA_W-1:0]  dec_da,
  input  logic             dec_ld,
  input  logic             dec_br,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  output logic             stall_if,
  output logic             flush_if,
  output logic             bubble_id,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] hz_cnt
);

  typedef enum logic {RUN, BR_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [DEPTH-1:0]           sb_v_q, sb_rw_q, sb_ld_q;
  logic [DEPTH-1:0][RA_W-1:0] sb_da_q;
  logic [DEPTH-1:0]           sb_v_d, sb_rw_d, sb_ld_d;
  logic [DEPTH-1:0][RA_W-1:0] sb_da_d;
  logic [CNT_W-1:0]           hz_cnt_q, hz_cnt_d;
  logic [SEL_W:0]             match_a, match_b;
  logic                       hazard;

  // Returns {hazard, select}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SEL_W:0] src_match(input logic used, input logic [RA_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && sb_v_q[k] && sb_rw_q[k] && (sb_da_q[k] == addr) &&
          !((R0_ZERO != 0) && (addr == '0))) begin
        if ((FWD_EN != 0) && (!sb_ld_q[k] || (k == DEPTH - 1)))
          res = {1'b0, SEL_W'(k + 1)};
        else
          res = {1'b1, {SEL_W{1'b0}}};
      end
    end
    return res;
  endfunction

  always_comb begin
    match_a   = src_match(dec_valid & ~dec_ma, dec_aa);
    match_b   = src_match(dec_valid & ~dec_mb, dec_ba);
    hazard    = match_a[SEL_W] | match_b[SEL_W];
    fwd_a_sel = match_a[SEL_W-1:0];
    fwd_b_sel = match_b[SEL_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    stall_if  = hazard;
    bubble_id = hazard;
    flush_if  = 1'b0;
    if (BR_MODE == 0) begin
      if (ex_br_valid && ex_br_taken) begin
        flush_if  = 1'b1;
        bubble_id = 1'b1;
        stall_if  = 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (dec_valid && dec_br && !hazard) state_d = BR_WAIT;
        end
        BR_WAIT: begin
          if (ex_br_valid) begin
            state_d = RUN;
            if (ex_br_taken) begin
              flush_if  = 1'b1;
              bubble_id = 1'b1;
              stall_if  = 1'b0;
            end
          end else begin
            stall_if  = 1'b1;
            bubble_id = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // A bubbled decode slot enters EX as an invalid entry.
  always_comb begin
    sb_v_d  = {sb_v_q[DEPTH-2:0], dec_valid & ~bubble_id};
    sb_rw_d = {sb_rw_q[DEPTH-2:0], dec_rw};
    sb_ld_d = {sb_ld_q[DEPTH-2:0], dec_ld};
    sb_da_d = {sb_da_q[DEPTH-2:0], dec_da};
    hz_cnt_d = hz_cnt_q;
    if ((stall_if || bubble_id) && !(&hz_cnt_q)) hz_cnt_d = hz_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      sb_v_q   <= '0;
      sb_rw_q  <= '0;
      sb_ld_q  <= '0;
      sb_da_q  <= '0;
      hz_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sb_v_q   <= sb_v_d;
      sb_rw_q  <= sb_rw_d;
      sb_ld_q  <= sb_ld_d;
      sb_da_q  <= sb_da_d;
      hz_cnt_q <= hz_cnt_d;
    end
  end

  assign hz_cnt = hz_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of per-cycle vectors on the default build,
// plus hand sequences for no-forward, R0 hardwired, freeze-mode branch and reset.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid, dec_ma, dec_mb, dec_rw, dec_ld, dec_br;
  logic [2:0] dec_aa, dec_ba, dec_da;
  logic       ex_br_valid, ex_br_taken;

  logic        f_st, f_fl, f_bu;  logic [1:0] f_fa, f_fb;  logic [15:0] f_cnt;
  logic        n_st, n_fl, n_bu;  logic [1:0] n_fa, n_fb;  logic [15:0] n_cnt;
  logic        z_st, z_fl, z_bu;  logic [1:0] z_fa, z_fb;  logic [15:0] z_cnt;
  logic        b_st, b_fl, b_bu;  logic [1:0] b_fa, b_fb;  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_fwd (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
    .dec_ma(dec_ma), .dec_mb(dec_mb), .dec_rw(dec_rw), .dec_da(dec_da), .dec_ld(dec_ld),
    .dec_br(dec_br), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(f_st), .flush_if(f_fl), .bubble_id(f_bu), .fwd_a_sel(f_fa), .fwd_b_sel(f_fb),
    .hz_cnt(f_cnt));

  pipe_hazard_ctrl #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
    .dec_ma(dec_ma), .dec_mb(dec_mb), .dec_rw(dec_rw), .dec_da(dec_da), .dec_ld(dec_ld),
    .dec_br(dec_br), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(n_st), .flush_if(n_fl), .bubble_id(n_bu), .fwd_a_sel(n_fa), .fwd_b_sel(n_fb),
    .hz_cnt(n_cnt));

  pipe_hazard_ctrl #(.R0_ZERO(1)) u_r0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
    .dec_ma(dec_ma), .dec_mb(dec_mb), .dec_rw(dec_rw), .dec_da(dec_da), .dec_ld(dec_ld),
    .dec_br(dec_br), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(z_st), .flush_if(z_fl), .bubble_id(z_bu), .fwd_a_sel(z_fa), .fwd_b_sel(z_fb),
    .hz_cnt(z_cnt));

  pipe_hazard_ctrl #(.BR_MODE(1), .CNT_W(4)) u_brf (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
    .dec_ma(dec_ma), .dec_mb(dec_mb), .dec_rw(dec_rw), .dec_da(dec_da), .dec_ld(dec_ld),
    .dec_br(dec_br), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(b_st), .flush_if(b_fl), .bubble_id(b_bu), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
    .hz_cnt(b_cnt));

  typedef struct {
    logic v; logic [2:0] aa, ba; logic ma, mb, rw; logic [2:0] da; logic ld, br, bv, bt;
    logic st, fl, bu; logic [1:0] fa, fb; int cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [2:0] aa, logic [2:0] ba, logic ma, logic mb,
                              logic rw, logic [2:0] da, logic ld, logic br, logic bv, logic bt,
                              logic st, logic fl, logic bu, logic [1:0] fa, logic [1:0] fb,
                              int cnt);
    vec_t r;
    r.v = v; r.aa = aa; r.ba = ba; r.ma = ma; r.mb = mb; r.rw = rw; r.da = da; r.ld = ld;
    r.br = br; r.bv = bv; r.bt = bt; r.st = st; r.fl = fl; r.bu = bu; r.fa = fa; r.fb = fb;
    r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] aa, input logic [2:0] ba, input logic ma,
                       input logic mb, input logic rw, input logic [2:0] da, input logic ld,
                       input logic br, input logic bv, input logic bt);
    dec_valid = v; dec_aa = aa; dec_ba = ba; dec_ma = ma; dec_mb = mb; dec_rw = rw;
    dec_da = da; dec_ld = ld; dec_br = br; ex_br_valid = bv; ex_br_taken = bt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    //                v aa ba ma mb rw da ld br bv bt   st fl bu fa fb cnt
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 3, 0));
    vecs.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 2));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 4));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3, 0, 5));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", f_st, 0);
    chk("rst_bubble", f_bu, 0);
    chk("rst_cnt", f_cnt, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].aa, vecs[i].ba, vecs[i].ma, vecs[i].mb, vecs[i].rw,
            vecs[i].da, vecs[i].ld, vecs[i].br, vecs[i].bv, vecs[i].bt);
      #1;
      chk($sformatf("v%0d_stall", i), f_st, vecs[i].st);
      chk($sformatf("v%0d_flush", i), f_fl, vecs[i].fl);
      chk($sformatf("v%0d_bubble", i), f_bu, vecs[i].bu);
      chk($sformatf("v%0d_fwd_a", i), f_fa, vecs[i].fa);
      chk($sformatf("v%0d_fwd_b", i), f_fb, vecs[i].fb);
      chk($sformatf("v%0d_cnt", i), f_cnt, vecs[i].cnt);
    end

    // No forwarding: ALU producer must drain through all three stages.
    do_reset();
    drive(1, 0, 0, 1, 1, 1, 4, 0, 0, 0, 0);
    #1 chk("nf_wr_stall", n_st, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("nf_c%0d_stall", c), n_st, (c < 3) ? 1 : 0);
      chk($sformatf("nf_c%0d_fwd_a", c), n_fa, 0);
    end
    chk("nf_cnt", n_cnt, 3);

    // R0 hardwired zero vs. ordinary R0.
    do_reset();
    drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r0z_fwd_a", z_fa, 0);
    chk("r0z_stall", z_st, 0);
    chk("r0n_fwd_a", f_fa, 1);

    // Freeze-mode branch: two wait cycles, taken resolve, then back in RUN.
    do_reset();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    #1 chk("bf_issue_stall", b_st, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("bf_w%0d_stall", c), b_st, 1);
      chk($sformatf("bf_w%0d_bubble", c), b_bu, 1);
    end
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    #1;
    chk("bf_res_flush", b_fl, 1);
    chk("bf_res_stall", b_st, 0);
    chk("bf_res_bubble", b_bu, 1);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    #1;
    chk("bf_run_stall", b_st, 0);
    chk("bf_run_flush", b_fl, 0);
    chk("bf_run_cnt", b_cnt, 3);

    // Hold the branch unresolved long enough to saturate the 4-bit counter.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    end
    #1;
    chk("bf_sat_stall", b_st, 1);
    chk("bf_sat_cnt", b_cnt, 15);

    // Asynchronous reset in the middle of BR_WAIT.
    #2 reset = 1'b1;
    #1;
    chk("t1_stall", b_st, 0);
    chk("t1_bubble", b_bu, 0);
    chk("t1_flush", b_fl, 0);
    chk("t1_cnt", b_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_run_stall", b_st, 0);
    @(negedge clk);
    #1;
    chk("t1_run_stall2", b_st, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
